// File: rtl/pa_f_spsram_ctrl_pkg.sv
// Shared types and constants for the single-port SRAM request controller.
package pa_f_spsram_ctrl_pkg;

  // Controller phase: zero-fill sweep, then normal traffic
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Idle levels of the active-low macro strobes
  localparam logic CEN_IDLE  = 1'b1;
  localparam logic GWEN_IDLE = 1'b1;

endpackage

// File: rtl/pa_f_spsram_init_seq.sv
// Post-reset zero-fill sequencer: walks every address once, then flags done.
module pa_f_spsram_init_seq
  import pa_f_spsram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 16,
  parameter bit          INIT_EN    = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  output logic                  o_init_done,
  output logic [ADDR_WIDTH-1:0] o_a_c,
  output logic                  o_cen_c,
  output logic                  o_gwen_c,
  output logic [DATA_WIDTH-1:0] o_wen_c
);

  state_e                r_state;
  logic [ADDR_WIDTH-1:0] r_init_cnt;
  logic                  r_init_done;
  logic                  w_init_act;

  // Sweep counter and INIT->RUN transition; done flag tracks RUN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= INIT_EN ? ST_INIT : ST_RUN;
      r_init_cnt  <= '0;
      r_init_done <= ~INIT_EN;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_init_cnt <= r_init_cnt + ADDR_WIDTH'(1);
          if (&r_init_cnt) begin
            r_state     <= ST_RUN;
            r_init_done <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

  // Zero-write strobes while sweeping; idle while reset is held
  always_comb begin
    w_init_act = (r_state == ST_INIT) & ~i_rst;
    o_a_c      = r_init_cnt;
    o_cen_c    = w_init_act ? 1'b0 : CEN_IDLE;
    o_gwen_c   = w_init_act ? 1'b0 : GWEN_IDLE;
    o_wen_c    = w_init_act ? '0 : '1;
  end

  assign o_init_done = r_init_done;

endmodule

// File: rtl/pa_f_spsram_ctrl.sv
// Valid/ready front end for a single-port SRAM macro with a 2-deep read pipe.
module pa_f_spsram_ctrl
  import pa_f_spsram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 16,
  parameter bit          INIT_EN    = 1'b1
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_bmask,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  logic                  w_init_done;
  logic [ADDR_WIDTH-1:0] w_init_a;
  logic                  w_init_cen;
  logic                  w_init_gwen;
  logic [DATA_WIDTH-1:0] w_init_wen;

  logic                  r_s1_vld;
  logic                  r_rsp_vld;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;

  logic                  w_s1_stall;
  logic                  w_acc;
  logic                  w_acc_wr;
  logic                  w_acc_rd;
  logic                  w_rsp_load;

  pa_f_spsram_init_seq #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .INIT_EN    (INIT_EN)
  ) u_init_seq (
    .i_clk       (forever_cpuclk),
    .i_rst       (cpurst),
    .o_init_done (w_init_done),
    .o_a_c       (w_init_a),
    .o_cen_c     (w_init_cen),
    .o_gwen_c    (w_init_gwen),
    .o_wen_c     (w_init_wen)
  );

  // Accept rule: only in RUN, and never while s1 is blocked by the response reg
  always_comb begin
    w_s1_stall = r_s1_vld & r_rsp_vld & ~rsp_rdy;
    req_rdy    = w_init_done & ~w_s1_stall & ~cpurst;
    w_acc      = req_vld & req_rdy;
    w_acc_wr   = w_acc & req_wr;
    w_acc_rd   = w_acc & ~req_wr;
    w_rsp_load = r_s1_vld & (~r_rsp_vld | rsp_rdy);
  end

  // Strobe mux: sweep strobes until done, then the accepted request
  always_comb begin
    sram_a    = req_addr;
    sram_cen  = CEN_IDLE;
    sram_gwen = GWEN_IDLE;
    sram_wen  = '1;
    sram_d    = req_wdata;
    if (!w_init_done) begin
      sram_a    = w_init_a;
      sram_cen  = w_init_cen;
      sram_gwen = w_init_gwen;
      sram_wen  = w_init_wen;
      sram_d    = '0;
    end else if (w_acc) begin
      sram_cen = 1'b0;
      if (w_acc_wr) begin
        sram_gwen = 1'b0;
        sram_wen  = ~req_bmask;
      end
    end
  end

  // s1 tracks the read in flight on sram_q; response reg holds it for the consumer
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      r_s1_vld    <= 1'b0;
      r_rsp_vld   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      if (w_rsp_load) begin
        r_rsp_rdata <= sram_q;
        r_rsp_vld   <= 1'b1;
      end else if (rsp_rdy) begin
        r_rsp_vld <= 1'b0;
      end
      if (w_acc_rd) begin
        r_s1_vld <= 1'b1;
      end else if (w_rsp_load) begin
        r_s1_vld <= 1'b0;
      end
    end
  end

  assign rsp_vld   = r_rsp_vld;
  assign rsp_rdata = r_rsp_rdata;
  assign init_done = w_init_done;

endmodule

// File: tb/tb_pa_f_spsram_ctrl.sv
// Directed bench for pa_f_spsram_ctrl with a behavioural single-port macro.
module tb_pa_f_spsram_ctrl;

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 16;
  localparam int unsigned DEPTH = 1 << AW;

  logic          forever_cpuclk = 1'b0;
  logic          cpurst;
  logic          req_vld, req_rdy, req_wr;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata, req_bmask;
  logic          rsp_vld, rsp_rdy;
  logic [DW-1:0] rsp_rdata;
  logic          init_done;
  logic [AW-1:0] sram_a;
  logic          sram_cen, sram_gwen;
  logic [DW-1:0] sram_wen, sram_d, sram_q;

  logic          preload;
  logic [DW-1:0] mem [DEPTH];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 forever_cpuclk = ~forever_cpuclk;

  pa_f_spsram_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .INIT_EN    (1'b1)
  ) dut (
    .forever_cpuclk (forever_cpuclk),
    .cpurst         (cpurst),
    .req_vld        (req_vld),
    .req_rdy        (req_rdy),
    .req_wr         (req_wr),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_bmask      (req_bmask),
    .rsp_vld        (rsp_vld),
    .rsp_rdy        (rsp_rdy),
    .rsp_rdata      (rsp_rdata),
    .init_done      (init_done),
    .sram_a         (sram_a),
    .sram_cen       (sram_cen),
    .sram_gwen      (sram_gwen),
    .sram_wen       (sram_wen),
    .sram_d         (sram_d),
    .sram_q         (sram_q)
  );

  // Macro model: per-bit active-low WEN, Q updates only on a read access
  always @(posedge forever_cpuclk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 16'hDEAD;
      sram_q <= 16'hBEEF;
    end else if (!sram_cen) begin
      if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else            sram_q      <= mem[sram_a];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge forever_cpuclk);
    #1;
  endtask

  // Present a request and hold it until the edge that accepts it
  task automatic do_req(input logic wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [DW-1:0] bmask);
    int k;
    req_vld = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata; req_bmask = bmask;
    #1;
    k = 0;
    while (!req_rdy && k < 50) begin
      tick(); #1; k++;
    end
    if (!req_rdy) check("req_timeout", 32'(req_rdy), 32'd1);
    tick();
  endtask

  task automatic read_wait(input logic [AW-1:0] addr, output logic [DW-1:0] data, output int lat);
    do_req(1'b0, addr, '0, '0);
    req_vld = 1'b0;
    lat = 1;
    while (!rsp_vld && lat < 20) begin
      tick(); lat++;
    end
    data = rsp_rdata;
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (!init_done && n < 2000) begin
      tick(); n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int            n, lat, nz, got, nrd, stall, cyc, stale;
    logic [DW-1:0] d;
    logic [DW-1:0] rd_data [8];

    preload = 1'b1; cpurst = 1'b1; req_vld = 1'b0; req_wr = 1'b0;
    req_addr = '0; req_wdata = '0; req_bmask = '0; rsp_rdy = 1'b1;
    tick(); tick();
    #1;
    check("rst_req_rdy",   32'(req_rdy),   32'd0);
    check("rst_cen",       32'(sram_cen),  32'd1);
    check("rst_rsp_vld",   32'(rsp_vld),   32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);

    // Sweep from reset: first write at address 0, done after 512 cycles
    tick();
    preload = 1'b0; cpurst = 1'b0;
    #1;
    check("init_first_cen", 32'(sram_cen),  32'd1 - 32'd1);
    check("init_first_a",   32'(sram_a),    32'd0);
    check("init_req_rdy",   32'(req_rdy),   32'd0);
    wait_init(n);
    check("init_cycles",   32'(n),         32'd512);
    #1;
    check("run_req_rdy",   32'(req_rdy),   32'd1);
    nz = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== 16'h0000) nz++;
    check("zero_fill", 32'(nz), 32'd0);

    // Partial-mask write merge; empty mask still pulses cen but writes nothing
    do_req(1'b1, 9'h010, 16'hA5A5, 16'hFFFF);
    do_req(1'b1, 9'h010, 16'h00FF, 16'h00F0);
    req_vld = 1'b1; req_wr = 1'b1; req_addr = 9'h010; req_wdata = 16'hFFFF; req_bmask = 16'h0000;
    #1;
    check("mask0_cen", 32'(sram_cen), 32'd0);
    tick();
    req_vld = 1'b0;
    read_wait(9'h010, d, lat);
    check("merge_data", 32'(d),   32'h0000A5F5);
    check("merge_lat",  32'(lat), 32'd2);
    tick();
    check("rsp_drain", 32'(rsp_vld), 32'd0);

    // Back-to-back reads with a stall after the first response
    for (int i = 0; i < 8; i++) do_req(1'b1, AW'(i), DW'(16'h0100 + i), 16'hFFFF);
    req_vld = 1'b0;
    got = 0; nrd = 0; stall = 0; cyc = 0;
    while (got < 8 && cyc < 200) begin
      rsp_rdy = !(got >= 1 && stall < 10);
      if (!rsp_rdy) stall++;
      req_vld = (nrd < 8); req_wr = 1'b0; req_addr = AW'(nrd);
      #1;
      if (stall == 5 && !rsp_rdy) begin
        check("stall_req_rdy", 32'(req_rdy),   32'd0);
        check("stall_cen",     32'(sram_cen),  32'd1);
        check("stall_rsp_vld", 32'(rsp_vld),   32'd1);
        check("stall_hold",    32'(rsp_rdata), 32'h00000101);
      end
      if (rsp_vld && rsp_rdy) begin
        rd_data[got] = rsp_rdata; got++;
      end
      if (req_vld && req_rdy) nrd++;
      tick(); cyc++;
    end
    req_vld = 1'b0; rsp_rdy = 1'b1;
    check("bp_count", 32'(got), 32'd8);
    check("bp_issued", 32'(nrd), 32'd8);
    for (int i = 0; i < 8; i++) check($sformatf("bp_data%0d", i), 32'(rd_data[i]), 32'h0100 + 32'(i));
    check("bp_empty", 32'(rsp_vld), 32'd0);

    // Write then immediate read of the top address
    do_req(1'b1, 9'h1FF, 16'h1234, 16'hFFFF);
    read_wait(9'h1FF, d, lat);
    check("raw_top_data", 32'(d),   32'h00001234);
    check("raw_top_lat",  32'(lat), 32'd2);
    tick();

    // Reset in the middle of a sweep restarts it at address 0
    cpurst = 1'b1;
    tick();
    cpurst = 1'b0;
    for (int i = 0; i < 300; i++) tick();
    #1;
    check("mid_sweep_a", 32'(sram_a), 32'd300);
    cpurst = 1'b1;
    #1;
    check("mid_rst_cen",     32'(sram_cen), 32'd1);
    check("mid_rst_req_rdy", 32'(req_rdy),  32'd0);
    tick();
    cpurst = 1'b0;
    #1;
    check("restart_a",   32'(sram_a),   32'd0);
    check("restart_cen", 32'(sram_cen), 32'd0);
    wait_init(n);
    check("restart_cycles", 32'(n), 32'd512);
    check("reinit_top", 32'(mem[9'h1FF]), 32'd0);

    // Reset with a pending response drops it; nothing stale after re-init
    rsp_rdy = 1'b0;
    do_req(1'b1, 9'h003, 16'h7777, 16'hFFFF);
    read_wait(9'h003, d, lat);
    check("pend_vld",  32'(rsp_vld), 32'd1);
    check("pend_data", 32'(d),       32'h00007777);
    cpurst = 1'b1;
    tick();
    check("pend_drop", 32'(rsp_vld), 32'd0);
    cpurst = 1'b0; rsp_rdy = 1'b1;
    n = 0; stale = 0;
    while (!init_done && n < 2000) begin
      tick(); n++;
      if (rsp_vld) stale++;
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (rsp_vld) stale++;
    end
    check("pend_reinit_cycles", 32'(n),     32'd512);
    check("no_stale_rsp",       32'(stale), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
